// File: rtl/poly_addsub_ctrl.sv
// poly_addsub_ctrl: full-polynomial coefficient-wise modular add/sub
// sequencer. r[i] = (a[i] +/- b[i]) mod MODULUS, one beat per cycle.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, op_sub, hold      pass request, add/sub select, issue stall
//   busy, done, range_err    pass status (range_err is sticky)
//   rd_en, rd_addr           shared operand RAM read port
//   rd_data_a, rd_data_b     operands, valid RD_LAT cycles after rd_en
//   wr_en, wr_addr, wr_data  result RAM write port
module poly_addsub_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int MODULUS    = 3329,
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int W1 = DATA_WIDTH + 1;
  localparam logic [W1-1:0] MOD = W1'(MODULUS);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  sub_q;
  logic                  busy_q;
  logic                  done_q;

  logic [RD_LAT-1:0]     vld_q;
  logic [ADDR_WIDTH-1:0] pa_q [RD_LAT];
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  range_q;

  logic                  start_acc;
  logic                  beat_v;
  logic [W1-1:0]         a_x;
  logic [W1-1:0]         b_x;
  logic [W1-1:0]         sum;
  logic [W1-1:0]         dif;
  logic [W1-1:0]         res_x;
  logic                  bad;

  // Issue is combinational so hold gates rd_en in the same cycle.
  assign rd_en     = (state_q == S_RUN) && !hold;
  assign rd_addr   = cnt_q;
  assign start_acc = (state_q == S_IDLE) && start;

  assign busy      = busy_q;
  assign done      = done_q;
  assign range_err = range_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // Operands arrive with the oldest valid bit of the pipeline.
  assign beat_v = vld_q[RD_LAT-1];

  always_comb begin
    a_x   = {1'b0, rd_data_a};
    b_x   = {1'b0, rd_data_b};
    sum   = a_x + b_x;
    dif   = a_x - b_x;
    res_x = sum;
    if (sub_q) begin
      res_x = (a_x >= b_x) ? dif : dif + MOD;
    end else begin
      res_x = (sum >= MOD) ? sum - MOD : sum;
    end
    bad = (a_x >= MOD) || (b_x >= MOD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            sub_q   <= op_sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // The counter parks on the last address so rd_addr holds.
          if (rd_en) begin
            if (cnt_q == LAST) begin
              state_q <= S_DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Empty valid pipe here means the last write is this cycle.
          if (vld_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pa_q[i] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      range_q   <= 1'b0;
    end else begin
      vld_q[0] <= rd_en;
      pa_q[0]  <= cnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end
      wr_en_q <= beat_v;
      if (beat_v) begin
        wr_addr_q <= pa_q[RD_LAT-1];
        wr_data_q <= res_x[DATA_WIDTH-1:0];
      end
      if (start_acc) begin
        range_q <= 1'b0;
      end else if (beat_v && bad) begin
        range_q <= 1'b1;
      end
    end
  end

endmodule
